// File: rtl/reg_file.sv
// 32x32 integer register file: x0 hardwired to zero, two combinational read
// ports with write-back bypass, a registered debug read port and a write-back counter.
module reg_file #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_wen,
  input  logic [AW-1:0]   reg_waddr,
  input  logic [XLEN-1:0] reg_wdata,
  input  logic [AW-1:0]   rs1_raddr,
  input  logic [AW-1:0]   rs2_raddr,
  output logic [XLEN-1:0] rs1_rdata,
  output logic [XLEN-1:0] rs2_rdata,
  input  logic [AW-1:0]   dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [XLEN-1:0] wb_count
);

  localparam int NUM_RD = 3;  // rs1, rs2, debug

  logic [NUM_REGS-1:0][XLEN-1:0] regs;
  logic [NUM_RD-1:0][AW-1:0]     rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]   rd_data;
  logic [XLEN-1:0]               wb_cnt;
  logic [XLEN-1:0]               dbg_q;
  logic                          commit;

  assign commit     = reg_wen && (reg_waddr != '0);
  assign rd_addr[0] = rs1_raddr;
  assign rd_addr[1] = rs2_raddr;
  assign rd_addr[2] = dbg_raddr;

  // Every read lane sees the in-flight write-back so decode never waits a cycle.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    always_comb begin
      rd_data[i] = regs[rd_addr[i]];
      if (rd_addr[i] == '0)
        rd_data[i] = '0;
      else if (commit && (reg_waddr == rd_addr[i]))
        rd_data[i] = reg_wdata;
    end
  end

  // regs[0] is only ever reset, never written, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs   <= '0;
      wb_cnt <= '0;
      dbg_q  <= '0;
    end else begin
      if (commit) begin
        regs[reg_waddr] <= reg_wdata;
        wb_cnt          <= wb_cnt + 1'b1;
      end
      dbg_q <= rd_data[2];
    end
  end

  assign rs1_rdata = rd_data[0];
  assign rs2_rdata = rd_data[1];
  assign dbg_rdata = dbg_q;
  assign wb_count  = wb_cnt;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: inputs change on the falling edge, outputs are
// sampled away from the rising edge and compared against hand-computed values.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [4:0]  rs1_raddr, rs2_raddr, dbg_raddr;
  logic [31:0] rs1_rdata, rs2_rdata, dbg_rdata, wb_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_wen   (reg_wen),
    .reg_waddr (reg_waddr),
    .reg_wdata (reg_wdata),
    .rs1_raddr (rs1_raddr),
    .rs2_raddr (rs2_raddr),
    .rs1_rdata (rs1_rdata),
    .rs2_rdata (rs2_rdata),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .wb_count  (wb_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    reg_wen   = en;
    reg_waddr = a;
    reg_wdata = d;
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr(1'b0, 5'd0, 32'h0);
    rs1_raddr = '0; rs2_raddr = '0; dbg_raddr = '0;
    #2;

    // Held in reset: everything cleared.
    for (int i = 0; i < 32; i++) begin
      rs1_raddr = 5'(i);
      rs2_raddr = 5'(31 - i);
      #1;
      chk($sformatf("rst_rs1_x%0d", i), rs1_rdata, 32'h0);
      chk($sformatf("rst_rs2_x%0d", 31 - i), rs2_rdata, 32'h0);
    end
    chk("rst_wb_count", wb_count, 32'h0);
    chk("rst_dbg", dbg_rdata, 32'h0);

    // Bypass still visible in reset, but the write is discarded.
    @(negedge clk);
    wr(1'b1, 5'd4, 32'h4444_0004);
    rs1_raddr = 5'd4; dbg_raddr = 5'd4;
    #1;
    chk("rst_bypass_rs1", rs1_rdata, 32'h4444_0004);
    step();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("rst_write_dropped", rs1_rdata, 32'h0);
    chk("rst_write_no_count", wb_count, 32'h0);
    chk("rst_dbg_held", dbg_rdata, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // x5 write with same-cycle read: bypass then stored value.
    @(negedge clk);
    wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    rs1_raddr = 5'd5;
    #1;
    chk("x5_bypass", rs1_rdata, 32'hDEAD_BEEF);
    chk("x5_pre_count", wb_count, 32'h0);
    step();
    chk("x5_count", wb_count, 32'h1);
    wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("x5_stored", rs1_rdata, 32'hDEAD_BEEF);

    // Write to x0 is dropped everywhere.
    @(negedge clk);
    wr(1'b1, 5'd0, 32'h1234_5678);
    rs1_raddr = 5'd0; rs2_raddr = 5'd0; dbg_raddr = 5'd0;
    #1;
    chk("x0_rs1", rs1_rdata, 32'h0);
    chk("x0_rs2", rs2_rdata, 32'h0);
    step();
    chk("x0_count", wb_count, 32'h1);
    chk("x0_dbg", dbg_rdata, 32'h0);

    // Both ports on the same bypassed index, then independent indices.
    @(negedge clk);
    wr(1'b1, 5'd9, 32'hCAFE_0009);
    rs1_raddr = 5'd9; rs2_raddr = 5'd9;
    #1;
    chk("dual_rs1_byp", rs1_rdata, 32'hCAFE_0009);
    chk("dual_rs2_byp", rs2_rdata, 32'hCAFE_0009);
    rs2_raddr = 5'd5;
    #1;
    chk("dual_rs2_indep", rs2_rdata, 32'hDEAD_BEEF);
    step();
    chk("dual_count", wb_count, 32'h2);

    // Back-to-back x7 writes seen on the debug port one cycle later each.
    @(negedge clk);
    dbg_raddr = 5'd7;
    wr(1'b1, 5'd7, 32'h1);
    step();
    chk("dbg_x7_first", dbg_rdata, 32'h1);
    @(negedge clk);
    wr(1'b1, 5'd7, 32'h2);
    step();
    chk("dbg_x7_second", dbg_rdata, 32'h2);
    @(negedge clk);
    wr(1'b0, 5'd0, 32'h0);
    rs1_raddr = 5'd7; rs2_raddr = 5'd9;
    step();
    chk("dbg_x7_hold", dbg_rdata, 32'h2);
    chk("x7_rs1_last", rs1_rdata, 32'h2);
    chk("x9_rs2_kept", rs2_rdata, 32'hCAFE_0009);
    chk("b2b_count", wb_count, 32'h4);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.wb_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.wb_cnt;
    #1;
    chk("wrap_preload", wb_count, 32'hFFFF_FFFF);
    wr(1'b1, 5'd1, 32'h0000_0011);
    step();
    chk("wrap_zero", wb_count, 32'h0);

    // Mid-stream reset between edges clears state at once.
    @(negedge clk);
    wr(1'b1, 5'd3, 32'hA5A5_A5A5);
    dbg_raddr = 5'd3;
    step();
    wr(1'b0, 5'd0, 32'h0);
    rs1_raddr = 5'd3; rs2_raddr = 5'd5;
    #1;
    chk("x3_stored", rs1_rdata, 32'hA5A5_A5A5);
    chk("x3_dbg", dbg_rdata, 32'hA5A5_A5A5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_x3", rs1_rdata, 32'h0);
    chk("async_x5", rs2_rdata, 32'h0);
    chk("async_count", wb_count, 32'h0);
    chk("async_dbg", dbg_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation resumes after reset.
    @(negedge clk);
    wr(1'b1, 5'd31, 32'hFFFF_FFFF);
    rs2_raddr = 5'd31;
    #1;
    chk("post_rst_byp", rs2_rdata, 32'hFFFF_FFFF);
    step();
    chk("post_rst_count", wb_count, 32'h1);
    wr(1'b0, 5'd0, 32'h0);
    #1;
    chk("post_rst_x31", rs2_rdata, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
